// File: rtl/rx_pkg.sv
// Shared constants and state encoding for the RX length/type counter.
// Define RX_JUMBO_EN to raise the word overrun limit to 9000-byte jumbo frames.
package rx_pkg;

    localparam logic [15:0] MIN_DATA = 16'd46;
    localparam logic [15:0] MAX_DATA = 16'd1500;
    localparam logic [15:0] TPID     = 16'h8100;
    localparam logic [15:0] TYPE_MIN = 16'h0600;

    localparam int MAX_WORDS_STD   = 188;
    localparam int MAX_WORDS_JUMBO = 1125;
`ifdef RX_JUMBO_EN
    localparam int MAX_WORDS = MAX_WORDS_JUMBO;
`else
    localparam int MAX_WORDS = MAX_WORDS_STD;
`endif

    typedef enum logic [2:0] {
        CNT_IDLE = 3'b001,
        CNT_RUN  = 3'b010,
        CNT_DONE = 3'b100
    } cnt_state_e;

    // Number of 8-byte words needed to carry a byte count.
    function automatic logic [15:0] words_ceil(input logic [15:0] bytes);
        return (bytes + 16'd7) >> 3;
    endfunction

endpackage

// File: rtl/rx_len_counter_if.sv
// Frame-length counter bus: receive-engine events in, classification flags and pulses out.
interface rx_len_counter_if;
    logic        start_lt;
    logic [15:0] lt_data;
    logic        start_data_cnt;
    logic        start_tagged_cnt;
    logic        term_seen;
    logic        recv_end;
    logic        tagged_frame;
    logic        small_frame;
    logic        len_invalid;
    logic        end_data_cnt;
    logic        end_tagged_cnt;
    logic        end_small_cnt;
    logic        length_error;

    modport master (
        output start_lt, lt_data, start_data_cnt, start_tagged_cnt, term_seen, recv_end,
        input  tagged_frame, small_frame, len_invalid, end_data_cnt, end_tagged_cnt,
               end_small_cnt, length_error
    );

    modport slave (
        input  start_lt, lt_data, start_data_cnt, start_tagged_cnt, term_seen, recv_end,
        output tagged_frame, small_frame, len_invalid, end_data_cnt, end_tagged_cnt,
               end_small_cnt, length_error
    );
endinterface

// File: rtl/rx_word_cnt.sv
// Saturating 8-byte word counter; flags the enable cycle that makes the count
// reach the padded target, the unpadded small-frame target, or pass the overrun limit.
module rx_word_cnt #(
    parameter int CNT_W = 11
) (
    input  logic             rxclk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] target,
    input  logic [CNT_W-1:0] small_target,
    input  logic [CNT_W-1:0] max_words,
    output logic             hit_target,
    output logic             hit_small,
    output logic             over
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + ONE;

    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n)  cnt_q <= '0;
        else if (clr)  cnt_q <= '0;
        else if (en)   cnt_q <= cnt_inc;
    end

    // Compare against the post-increment value so the owner can register a
    // pulse that lands exactly one cycle after the enable cycle.
    assign hit_target = en && (cnt_inc == target);
    assign hit_small  = en && (cnt_inc == small_target);
    assign over       = en && (cnt_inc >  max_words);
endmodule

// File: rtl/rx_len_counter.sv
// Classifies a received frame from its Length/Type field and counts data words
// to detect end of payload, padding and length errors (RX_JUMBO_EN: jumbo limit).
module rx_len_counter
    import rx_pkg::*;
#(
    parameter int CNT_W = 11
) (
    input  logic              rxclk,
    input  logic              reset_n,
    rx_len_counter_if.slave   bus
);
    localparam logic [CNT_W-1:0] MAXW = CNT_W'(MAX_WORDS);

    cnt_state_e       state_q, state_d;
    logic             is_len_q;
    logic [CNT_W-1:0] target_q, small_t_q;

    logic             d_tag, d_len, d_inv, d_small;
    logic [15:0]      pad_len;
    logic [CNT_W-1:0] d_target, d_small_t;

    logic start, en, clr, hit_target, hit_small, over, run_done;

    logic tag_q, small_q, inv_q, end_d_q, end_t_q, end_s_q, lerr_q;
    logic tag_d, small_d, inv_d, end_d_d, end_t_d, end_s_d, lerr_d;

    // Length/Type decode
    assign d_tag     = (bus.lt_data == TPID);
    assign d_len     = (bus.lt_data <= MAX_DATA);
    assign d_inv     = (bus.lt_data > MAX_DATA) && (bus.lt_data < TYPE_MIN);
    assign d_small   = d_len && (bus.lt_data < MIN_DATA);
    assign pad_len   = (bus.lt_data < MIN_DATA) ? MIN_DATA : bus.lt_data;
    assign d_target  = CNT_W'(words_ceil(pad_len));
    assign d_small_t = (bus.lt_data == 16'd0) ? CNT_W'(1) : CNT_W'(words_ceil(bus.lt_data));

    assign start = (state_q == CNT_IDLE) && bus.start_lt;
    assign en    = (state_q == CNT_RUN) && (bus.start_data_cnt || bus.start_tagged_cnt);
    assign clr   = start || bus.recv_end;

    rx_word_cnt #(.CNT_W(CNT_W)) u_word_cnt (
        .rxclk        (rxclk),
        .reset_n      (reset_n),
        .clr          (clr),
        .en           (en),
        .target       (target_q),
        .small_target (small_t_q),
        .max_words    (MAXW),
        .hit_target   (hit_target),
        .hit_small    (hit_small),
        .over         (over)
    );

    assign run_done = bus.term_seen || over || (is_len_q && hit_target);

    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CNT_IDLE;
            is_len_q  <= 1'b0;
            target_q  <= '0;
            small_t_q <= '0;
            tag_q     <= 1'b0;
            small_q   <= 1'b0;
            inv_q     <= 1'b0;
            end_d_q   <= 1'b0;
            end_t_q   <= 1'b0;
            end_s_q   <= 1'b0;
            lerr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                is_len_q  <= d_len;
                target_q  <= d_target;
                small_t_q <= d_small_t;
            end
            tag_q   <= tag_d;
            small_q <= small_d;
            inv_q   <= inv_d;
            end_d_q <= end_d_d;
            end_t_q <= end_t_d;
            end_s_q <= end_s_d;
            lerr_q  <= lerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CNT_IDLE: if (bus.start_lt) state_d = d_inv ? CNT_DONE : CNT_RUN;
            CNT_RUN:  if (run_done)     state_d = CNT_DONE;
            CNT_DONE: ;
            default:  state_d = CNT_IDLE;
        endcase
        if (bus.recv_end) state_d = CNT_IDLE;
    end

    // Next values of the registered outputs; recv_end aborts silently.
    always_comb begin
        tag_d   = tag_q;
        small_d = small_q;
        inv_d   = inv_q;
        end_d_d = 1'b0;
        end_t_d = 1'b0;
        end_s_d = 1'b0;
        lerr_d  = 1'b0;
        if (start) begin
            tag_d   = d_tag;
            small_d = d_small;
            inv_d   = d_inv;
        end
        if (state_q == CNT_RUN) begin
            if (is_len_q) begin
                if (hit_target)          end_d_d = 1'b1;
                else if (bus.term_seen)  lerr_d  = 1'b1;
                else if (over)           lerr_d  = 1'b1;
                if (small_q && hit_small) end_s_d = 1'b1;
            end else begin
                if (bus.term_seen) begin
                    if (tag_q) end_t_d = 1'b1;
                    else       end_d_d = 1'b1;
                end else if (over) begin
                    lerr_d = 1'b1;
                end
            end
        end
        if (bus.recv_end) begin
            tag_d   = 1'b0;
            small_d = 1'b0;
            inv_d   = 1'b0;
            end_d_d = 1'b0;
            end_t_d = 1'b0;
            end_s_d = 1'b0;
            lerr_d  = 1'b0;
        end
    end

    assign bus.tagged_frame   = tag_q;
    assign bus.small_frame    = small_q;
    assign bus.len_invalid    = inv_q;
    assign bus.end_data_cnt   = end_d_q;
    assign bus.end_tagged_cnt = end_t_q;
    assign bus.end_small_cnt  = end_s_q;
    assign bus.length_error   = lerr_q;
endmodule

// File: doc/rx_len_counter.md
RX_LEN_COUNTER -- requirements
Module: rx_len_counter

Interface
REQ-001 Parameter: CNT_W, 11, width of the 8-byte data word counter.
REQ-002 rxclk  in  1  receive clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 start_lt  in  1  high for the single cycle in which lt_data is valid.
REQ-005 lt_data  in  16  Length/Type field value, big-endian.
REQ-006 start_data_cnt  in  1  one data word (8 bytes) received this cycle, untagged frame.
REQ-007 start_tagged_cnt  in  1  one data word received this cycle, tagged frame.
REQ-008 term_seen  in  1  XGMII terminate detected this cycle.
REQ-009 recv_end  in  1  receive engine idle; aborts counting.
REQ-010 tagged_frame, small_frame  out  1 each  frame classification flags.
REQ-011 len_invalid  out  1  LT value is in the range 1501..1535.
REQ-012 end_data_cnt, end_tagged_cnt, end_small_cnt, length_error  out  1 each  single-cycle pulses.

Function
REQ-013 States: CNT_IDLE, CNT_RUN, CNT_DONE; one-hot encoded.
REQ-014 CNT_IDLE, start_lt=1: latch lt_data; decode; clear counter; go to CNT_RUN on the next edge.
REQ-015 Decode rules:
- lt_data==0x8100: tagged_frame=1.
- lt_data<=1500: length frame.
- 1501..1535: len_invalid=1, next state CNT_DONE.
- >=0x0600: type frame.
REQ-016 small_frame=1 for a length frame with lt_data<46.
REQ-017 Counter: increments by 1 in each CNT_RUN cycle in which start_data_cnt|start_tagged_cnt is high; saturates at 2^CNT_W-1.
REQ-018 Length frame: target = ceil(max(len,46)/8). end_data_cnt pulses the cycle after the enable cycle in which the counter reaches target; then go to CNT_DONE.
REQ-019 Small frame: end_small_cnt pulses the cycle after the counter reaches ceil(len/8), with len=0 treated as 1 word; counting continues to the padded target.
REQ-020 Type or tagged frame: the cycle after term_seen, pulse end_data_cnt (untagged) or end_tagged_cnt (tagged); go to CNT_DONE.
REQ-021 Length frame, term_seen before target is reached: pulse length_error the next cycle; go to CNT_DONE; no end_data_cnt pulse.
REQ-022 Overrun: counter exceeds MAX_WORDS (188) with no term_seen -> length_error pulse; go to CNT_DONE.
REQ-023 Same-cycle conflict: if target is reached and term_seen occur together, end_data_cnt wins; no length_error.
REQ-024 Flags tagged_frame, small_frame and len_invalid hold until the state returns to CNT_IDLE.
REQ-025 CNT_DONE -> CNT_IDLE when recv_end=1.
REQ-026 recv_end=1 in any state: next state CNT_IDLE; clear flags and counter; no pulse issued.
REQ-027 start_lt is ignored outside CNT_IDLE.
REQ-028 All outputs are registered.

Reset
REQ-029 reset_n=0 forces CNT_IDLE, counter 0, and all outputs 0 immediately, independent of rxclk; this includes reset mid-frame.
REQ-030 The first frame accepted after reset release is the one whose start_lt arrives in CNT_IDLE.

Configuration
REQ-031 Macro RX_JUMBO_EN:
- Defined: MAX_WORDS=1125 (9000 bytes), and type frames may exceed 1500 bytes without error.
- Undefined: MAX_WORDS=188; no other behaviour changes.

Structure
REQ-032 Shared package rx_pkg holds: MIN_DATA=46, MAX_DATA=1500, TPID=0x8100, TYPE_MIN=0x0600, MAX_WORDS (both values), and the state encoding.
REQ-033 One sub-module, rx_word_cnt: the saturating counter with compare-to-target pulse generation.

Verification
REQ-034 lt_data=100, 13 enable cycles -> end_data_cnt pulse 1 cycle after the 13th; length_error stays 0.
REQ-035 lt_data=20, 6 enable cycles -> small_frame=1; end_small_cnt after the 3rd word; end_data_cnt after the 6th.
REQ-036 lt_data=0x0800, 30 words then term_seen -> end_data_cnt pulse the next cycle; no length_error.
REQ-037 lt_data=1000, term_seen after 50 words -> length_error pulse; no end_data_cnt.
REQ-038 lt_data=0x8100, 189 words -> length_error (RX_JUMBO_EN off); same stimulus with RX_JUMBO_EN on -> no error.
REQ-039 reset_n low at word 5 of a 100-byte frame -> all outputs 0; next frame with lt_data=64 counts 8 words correctly.
